// File: rtl/cmdrdctrl.sv
// Command-frame reader: hunts for EB 90, checks type 04, decodes the code byte and streams PAYLOAD_LEN bytes.
// Optional mid-frame idle timeout is built only when CMDRD_TIMEOUT_EN is defined.
module cmdrdctrl #(
    parameter int PAYLOAD_LEN = 8,
    parameter int TIMEOUT     = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       empty,
    input  logic [7:0] rdata,
    output logic       ren,
    input  logic       hold,
    output logic [4:0] cmd,
    output logic       newcmd,
    output logic [7:0] dout,
    output logic       dvalid,
    output logic       frame_done,
    output logic       frame_err
);
    localparam int CW = $clog2(PAYLOAD_LEN + 1);

    typedef enum logic [2:0] {HUNT, SYNC2, TYPE, CODE, PAYLOAD} state_t;

    state_t          state, state_d;
    logic            rvld;
    logic [CW-1:0]   cnt, cnt_d, cnt_inc;
    logic [4:0]      cmd_d, code_oh;
    logic [7:0]      dout_d;
    logic            newcmd_d, dvalid_d, frame_done_d, frame_err_d;
    logic            last_byte;

    assign ren       = !empty && !hold;
    assign cnt_inc   = cnt + CW'(1);
    assign last_byte = (cnt_inc == CW'(PAYLOAD_LEN));

    always_comb begin
        code_oh = 5'b00000;
        case (rdata)
            8'h13:   code_oh = 5'b00001;
            8'h25:   code_oh = 5'b00010;
            8'h94:   code_oh = 5'b00100;
            8'h87:   code_oh = 5'b01000;
            8'h63:   code_oh = 5'b10000;
            default: code_oh = 5'b00000;
        endcase
    end

`ifdef CMDRD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt;
    logic          to_hit;

    // Counts idle cycles spent mid-frame; any processed byte restarts it.
    assign to_hit = (state != HUNT) && !rvld && ((to_cnt + TW'(1)) == TW'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            to_cnt <= '0;
        else if (rvld || state == HUNT || to_hit)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + TW'(1);
    end
`endif

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        cmd_d        = cmd;
        dout_d       = dout;
        newcmd_d     = 1'b0;
        dvalid_d     = 1'b0;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        if (rvld) begin
            case (state)
                HUNT: begin
                    if (rdata == 8'hEB) state_d = SYNC2;
                end
                SYNC2: begin
                    if (rdata == 8'h90)      state_d = TYPE;
                    else if (rdata == 8'hEB) state_d = SYNC2;
                    else                     state_d = HUNT;
                end
                TYPE: begin
                    if (rdata == 8'h04) begin
                        state_d = CODE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = HUNT;
                    end
                end
                CODE: begin
                    if (|code_oh) begin
                        cmd_d    = code_oh;
                        newcmd_d = 1'b1;
                        cnt_d    = '0;
                        state_d  = PAYLOAD;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = HUNT;
                    end
                end
                PAYLOAD: begin
                    // Payload is opaque: an embedded EB 90 is just data.
                    dout_d   = rdata;
                    dvalid_d = 1'b1;
                    cnt_d    = cnt_inc;
                    if (last_byte) begin
                        frame_done_d = 1'b1;
                        state_d      = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
`ifdef CMDRD_TIMEOUT_EN
        else if (to_hit) begin
            frame_err_d = 1'b1;
            state_d     = HUNT;
            cnt_d       = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            rvld       <= 1'b0;
            cnt        <= '0;
            cmd        <= '0;
            dout       <= '0;
            newcmd     <= 1'b0;
            dvalid     <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_d;
            rvld       <= ren;
            cnt        <= cnt_d;
            cmd        <= cmd_d;
            dout       <= dout_d;
            newcmd     <= newcmd_d;
            dvalid     <= dvalid_d;
            frame_done <= frame_done_d;
            frame_err  <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_cmdrdctrl.sv
// Scoreboard bench for cmdrdctrl: a byte-queue FIFO model feeds the DUT, expected events are queued at issue time.
// Build with CMDRD_TIMEOUT_EN defined to exercise the timeout path (TIMEOUT overridden to 16).
module tb_cmdrdctrl;
    localparam int TO = 16;
    localparam logic [1:0] K_CMD = 2'd0, K_DAT = 2'd1, K_ERR = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [8:0] data;
    } ev_t;

    logic       clk = 1'b0, rst = 1'b1, empty = 1'b1, hold = 1'b0;
    logic [7:0] rdata = 8'h00;
    logic       ren, newcmd, dvalid, frame_done, frame_err;
    logic [4:0] cmd;
    logic [7:0] dout;

    ev_t        sb[$];
    logic [7:0] fifo[$];
    int total = 0, bad = 0;
    int cyc = 0, reads = 0, first_rd = -1, last_rd = -1;
    int last_dv_cyc = 0, err_cyc = 0;
    bit ren_s = 1'b0, h1 = 1'b0, h2 = 1'b0;

    cmdrdctrl #(.PAYLOAD_LEN(8), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .empty(empty), .rdata(rdata), .ren(ren), .hold(hold),
        .cmd(cmd), .newcmd(newcmd), .dout(dout), .dvalid(dvalid),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic exp_ev(input logic [1:0] k, input logic [8:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic exp_frame(input logic [4:0] oh, input logic [7:0] base);
        exp_ev(K_CMD, {4'b0, oh});
        for (int i = 0; i < 8; i++) exp_ev(K_DAT, {(i == 7), base + 8'(i)});
    endtask

    task automatic push_frame(input logic [7:0] code, input logic [7:0] base);
        fifo.push_back(8'hEB); fifo.push_back(8'h90); fifo.push_back(8'h04); fifo.push_back(code);
        for (int i = 0; i < 8; i++) fifo.push_back(base + 8'(i));
    endtask

    task automatic take(input logic [1:0] k, input int d, input string nm);
        ev_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_%s: got data %0h expected no event", nm, d);
        end else begin
            e = sb.pop_front();
            chk({nm, "_kind"}, int'(k), int'(e.kind));
            chk({nm, "_data"}, d, int'(e.data));
        end
    endtask

    // Drain until FIFO and scoreboard are empty, then return aligned 2 time units after a posedge.
    task automatic drain(input int maxc);
        int n = 0;
        while ((fifo.size() != 0 || sb.size() != 0) && n < maxc) begin
            @(posedge clk);
            n++;
        end
        if (n >= maxc) chk("drain_timeout", 1, 0);
        repeat (4) @(posedge clk);
        #2;
    endtask

    // FIFO model: a read issued in one cycle presents its byte in the next.
    initial forever begin
        @(posedge clk);
        #1;
        if (ren_s && fifo.size() > 0) rdata = fifo.pop_front();
        empty = (fifo.size() == 0);
    end

    // Monitor: pops the scoreboard on every output event.
    initial forever begin
        @(negedge clk);
        cyc++;
        ren_s = ren;
        if (!rst) begin
            if (ren) begin
                reads++;
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
            end
            if (h1 && h2) chk("dvalid_under_hold", int'(dvalid), 0);
            if (newcmd) take(K_CMD, int'(cmd), "cmd");
            if (dvalid) begin
                take(K_DAT, int'({frame_done, dout}), "dat");
                last_dv_cyc = cyc;
            end else if (frame_done) chk("done_without_dvalid", 1, 0);
            if (frame_err) begin
                take(K_ERR, 0, "err");
                err_cyc = cyc;
            end
        end
        h2 = h1;
        h1 = hold;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ren", int'(ren), 0);
        chk("rst_cmd", int'(cmd), 0);
        chk("rst_dout", int'(dout), 0);
        chk("rst_pulses", int'({newcmd, dvalid, frame_done, frame_err}), 0);
        @(posedge clk); #2;
        rst = 1'b0;

        // Basic frame, code 94
        exp_frame(5'b00100, 8'h01);
        push_frame(8'h94, 8'h01);
        drain(200);
        chk("reads", reads, 12);
        chk("read_span", last_rd - first_rd, 11);
        chk("ren_idle", int'(ren), 0);

        // Leading garbage, then back-to-back bad type and bad code frames
        exp_frame(5'b00001, 8'h11);
        exp_ev(K_ERR, 9'h0);
        exp_ev(K_ERR, 9'h0);
        fifo.push_back(8'h00); fifo.push_back(8'hEB);
        push_frame(8'h13, 8'h11);
        fifo.push_back(8'hEB); fifo.push_back(8'h90); fifo.push_back(8'h05);
        fifo.push_back(8'hEB); fifo.push_back(8'h90); fifo.push_back(8'h04); fifo.push_back(8'h55);
        drain(200);
        chk("cmd_kept", int'(cmd), 5'b00001);
        exp_frame(5'b00010, 8'h21);
        push_frame(8'h25, 8'h21);
        drain(200);

        // Hold toggled every 3 cycles while the frame streams
        exp_frame(5'b01000, 8'h31);
        push_frame(8'h87, 8'h31);
        for (int i = 0; i < 10; i++) begin
            repeat (3) @(posedge clk);
            #2;
            hold = ~hold;
        end
        hold = 1'b0;
        drain(200);

        // Reset mid-frame after payload byte 3
        exp_ev(K_CMD, 9'b00001_0000);
        exp_ev(K_DAT, 9'h041); exp_ev(K_DAT, 9'h042); exp_ev(K_DAT, 9'h043);
        fifo.push_back(8'hEB); fifo.push_back(8'h90); fifo.push_back(8'h04); fifo.push_back(8'h63);
        fifo.push_back(8'h41); fifo.push_back(8'h42); fifo.push_back(8'h43);
        drain(200);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_cmd", int'(cmd), 0);
        chk("midrst_dout", int'(dout), 0);
        chk("midrst_pulses", int'({newcmd, dvalid, frame_done, frame_err}), 0);
        @(posedge clk); #2;
        rst = 1'b0;
        exp_frame(5'b00001, 8'h51);
        push_frame(8'h13, 8'h51);
        drain(200);

        // FIFO runs dry after payload byte 2
        exp_ev(K_CMD, 9'b0_0010_0);
        exp_ev(K_DAT, 9'h061); exp_ev(K_DAT, 9'h062);
`ifdef CMDRD_TIMEOUT_EN
        exp_ev(K_ERR, 9'h0);
`endif
        fifo.push_back(8'hEB); fifo.push_back(8'h90); fifo.push_back(8'h04); fifo.push_back(8'h94);
        fifo.push_back(8'h61); fifo.push_back(8'h62);
        drain(200);
`ifdef CMDRD_TIMEOUT_EN
        chk("timeout_delay", err_cyc - last_dv_cyc, TO);
        for (int i = 3; i <= 8; i++) fifo.push_back(8'h60 + 8'(i));
        drain(200);
`else
        repeat (40) @(posedge clk);
        #2;
        for (int i = 3; i <= 8; i++) begin
            fifo.push_back(8'h60 + 8'(i));
            exp_ev(K_DAT, {(i == 8), 8'h60 + 8'(i)});
        end
        drain(200);
`endif
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cmdrdctrl.md
# cmdrdctrl

Command-frame reader and parser at the read side of the command FIFO. It pulls bytes from the FIFO and hunts for the `EB 90` sync word. It checks the frame-type byte, decodes the command code byte to a one-hot command, then streams a fixed-length payload downstream. Malformed frames are dropped, with an error pulse, and the parser resynchronises on the next sync word.

## Interface
Parameters:
- `PAYLOAD_LEN`, 8: payload bytes per frame after the code byte (1..255).
- `TIMEOUT`, 1024: idle cycles allowed mid-frame before abort (only with `CMDRD_TIMEOUT_EN`).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `empty`  in  1  FIFO empty flag.
- `rdata`  in  8  FIFO read data, valid one cycle after `ren`.
- `ren`  out  1  FIFO read enable.
- `hold`  in  1  downstream back-pressure; no new reads while high.
- `cmd`  out  5  one-hot decoded command, held until next `newcmd`.
- `newcmd`  out  1  one-cycle pulse: valid code byte accepted.
- `dout`  out  8  payload byte.
- `dvalid`  out  1  `dout` valid this cycle.
- `frame_done`  out  1  one-cycle pulse coincident with the last payload `dvalid`.
- `frame_err`  out  1  one-cycle pulse: frame dropped.

## Operation
- Read issue:
  - `ren = !empty && !hold`, combinational.
  - Registered `rvld <= ren`; a byte is processed only in cycles where `rvld` = 1.
  - One byte may still arrive after `hold` rises; it is processed normally.
- States: HUNT, SYNC2, TYPE, CODE, PAYLOAD.
  - HUNT: byte `EB` → SYNC2; any other byte is discarded silently.
  - SYNC2:
    - `90` → TYPE.
    - `EB` → stay in SYNC2.
    - Any other byte → HUNT, no error.
  - TYPE: `04` → CODE; any other byte → `frame_err`, HUNT.
  - CODE: decode as below, then load `cmd`, pulse `newcmd`, clear the payload counter and go to PAYLOAD. Any other byte → `frame_err`, HUNT, `cmd` unchanged.
    - `13` → `00001`
    - `25` → `00010`
    - `94` → `00100`
    - `87` → `01000`
    - `63` → `10000`
  - PAYLOAD: each byte → `dout`, `dvalid`, counter + 1. On the byte where the counter reaches `PAYLOAD_LEN` → `frame_done`, HUNT.
- Payload bytes are not interpreted; `EB 90` inside the payload is passed through as data.
- Payload counter is `$clog2(PAYLOAD_LEN+1)` bits, cleared in CODE, never wraps within a frame.
- Reset values:
  - Outputs: `ren` follows its equation, `cmd` = 0, `dout` = 0; `newcmd`, `dvalid`, `frame_done`, `frame_err` = 0.
  - Internal: state HUNT, `rvld` = 0, counter = 0.
- Reset asserted mid-frame: the frame is lost and the parser restarts in HUNT with no error pulse. Bytes read before reset are discarded.

## Timing
- `ren` high in cycle N → `rdata` sampled in N+1 → `dout`/`dvalid`/`newcmd`/`frame_err` registered, visible in N+2.
- Throughput is 1 byte/cycle with a non-empty FIFO and `hold` low, including back-to-back frames.
- Minimum frame length is 4 + `PAYLOAD_LEN` bytes.
- `frame_done` and the last `dvalid` assert in the same cycle.
- The first sync byte of the next frame may be processed in the cycle immediately after.
- `newcmd` precedes the first payload `dvalid` by at least one cycle.
- `empty` and `hold` may change in any cycle. State advances only on `rvld`; no output pulses occur without a processed byte, except the timeout pulse.

## Configuration
- `CMDRD_TIMEOUT_EN` defined:
  - A cycle counter runs while the state is not HUNT and `rvld` = 0; it clears on every `rvld`.
  - When it reaches `TIMEOUT`: `frame_err` pulses once, state → HUNT, payload counter clears.
  - A partially delivered payload is not completed (no `frame_done`).
- Not defined: no counter logic. The parser waits indefinitely mid-frame.

## Test plan
- FIFO holds `EB 90 04 94 01..08`, `hold` = 0:
  - `newcmd` with `cmd` = `00100`.
  - 8 consecutive `dvalid` with `dout` 01..08; `frame_done` on byte 08.
  - `ren` low after 12 reads.
- Leading garbage `00 EB EB 90 04 13` + payload: no `frame_err`; `cmd` = `00001`; payload delivered intact.
- `EB 90 05 ...` → one `frame_err`, no `newcmd`. `EB 90 04 55` → one `frame_err`, `cmd` keeps its previous value, next valid frame is parsed.
- `hold` toggled every 3 cycles during the payload → at most one `dvalid` after `hold` rises; all 8 bytes delivered in order, none duplicated.
- `rst` pulsed after payload byte 3 → all outputs 0 immediately. A fresh full frame afterwards produces a complete 8-byte payload and no `frame_err`.
- With `CMDRD_TIMEOUT_EN`, `TIMEOUT` = 16: FIFO empties after payload byte 2 → `frame_err` 16 cycles after the last `rvld`, no `frame_done`. Without the macro: no pulse, and the payload resumes when data returns.
